// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM state codes, instruction field positions.
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 16;
  localparam int SEQ_REG_AW = 3;

  typedef logic [SEQ_DATA_W-1:0] word_t;

  // Codes 0000..0101 are forwarded to the ALU unchanged.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SLR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_MV  = 4'b0110;
  localparam logic [3:0] OP_MVI = 4'b0111;

  localparam logic [1:0] ST_T0 = 2'd0;
  localparam logic [1:0] ST_T1 = 2'd1;
  localparam logic [1:0] ST_T2 = 2'd2;
  localparam logic [1:0] ST_T3 = 2'd3;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int X_HI  = 11;
  localparam int X_LO  = 9;
  localparam int Y_HI  = 8;
  localparam int Y_LO  = 6;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_AND;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and its environment (instruction source, external ALU, debug port).
interface alu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic              Done;
  logic              Busy;
  logic [REG_AW-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output Run, DIN, alu_result, dbg_sel,
    input  alu_a, alu_b, alu_op, Done, Busy, dbg_data
  );

  modport slave (
    input  Run, DIN, alu_result, dbg_sel,
    output alu_a, alu_b, alu_op, Done, Busy, dbg_data
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// 8x16 register file: one write port, combinational X/Y/debug reads, cleared by reset.
module seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int REG_AW = SEQ_REG_AW
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_xaddr,
  output logic [DATA_W-1:0] o_xdata,
  input  logic [REG_AW-1:0] i_yaddr,
  output logic [DATA_W-1:0] o_ydata,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);
  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_xdata    = r_mem[i_xaddr];
  assign o_ydata    = r_mem[i_yaddr];
  assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// Multicycle fetch/execute controller feeding an external combinational ALU; result lands in G, then R[X].
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int REG_AW = SEQ_REG_AW
) (
  input  logic          Clock,
  input  logic          Reset,
  alu_sequencer_if.slave bus
);
  logic [1:0]        r_state;
  logic [OP_HI:Y_LO] r_ir;   // IR[5:0] is never decoded, so it is not stored
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;

  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_x;
  logic [REG_AW-1:0] w_y;
  logic              w_alu_class;
  logic [DATA_W-1:0] w_xdata;
  logic [DATA_W-1:0] w_ydata;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;

  assign w_op        = r_ir[OP_HI:OP_LO];
  assign w_x         = r_ir[X_HI:X_LO];
  assign w_y         = r_ir[Y_HI:Y_LO];
  assign w_alu_class = is_alu_op(w_op);

  seq_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_we       (w_we),
    .i_waddr    (w_x),
    .i_wdata    (w_wdata),
    .i_xaddr    (w_x),
    .o_xdata    (w_xdata),
    .i_yaddr    (w_y),
    .o_ydata    (w_ydata),
    .i_dbg_addr (bus.dbg_sel),
    .o_dbg_data (bus.dbg_data)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_T0;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
    end else begin
      case (r_state)
        ST_T0: begin
          if (bus.Run) begin
            r_ir    <= bus.DIN[OP_HI:Y_LO];
            r_state <= ST_T1;
          end
        end
        ST_T1: begin
          // A is latched here so X==Y instructions see pre-write-back operands.
          if (w_alu_class) begin
            r_a     <= w_xdata;
            r_state <= ST_T2;
          end else begin
            r_state <= ST_T0;
          end
        end
        ST_T2: begin
          r_g     <= bus.alu_result;
          r_state <= ST_T3;
        end
        default: r_state <= ST_T0;
      endcase
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_wdata = '0;
    if (r_state == ST_T1 && w_op == OP_MV) begin
      w_we    = 1'b1;
      w_wdata = w_ydata;
    end else if (r_state == ST_T1 && w_op == OP_MVI) begin
      w_we    = 1'b1;
      w_wdata = bus.DIN;
    end else if (r_state == ST_T3) begin
      w_we    = 1'b1;
      w_wdata = r_g;
    end
  end

  assign bus.alu_a  = r_a;
  assign bus.alu_b  = w_ydata;
  assign bus.alu_op = w_alu_class ? w_op : 4'b0000;
  assign bus.Done   = (r_state == ST_T1 && !w_alu_class) || (r_state == ST_T3);
  assign bus.Busy   = (r_state != ST_T0);
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed bench for alu_sequencer with an instruction-level reference model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] m_reg [8];

  // External ALU behaviour: wrapping arithmetic, unsigned slt, shifts >= 16 give 0.
  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return (a < b) ? 16'd1 : 16'd0;
      4'd3: return (b >= 16) ? 16'd0 : (a << b);
      4'd4: return (b >= 16) ? 16'd0 : (a >> b);
      4'd5: return a & b;
      default: return 16'd0;
    endcase
  endfunction

  always_comb bus.alu_result = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);

  function automatic void model_exec(input logic [15:0] ir, input logic [15:0] imm);
    int op, x, y;
    logic [15:0] res;
    op = int'(ir[15:12]);
    x  = int'(ir[11:9]);
    y  = int'(ir[8:6]);
    if (op <= 5) begin
      res = ref_alu(ir[15:12], m_reg[x], m_reg[y]);
      m_reg[x] = res;
    end else if (op == 6) begin
      m_reg[x] = m_reg[y];
    end else if (op == 7) begin
      m_reg[x] = imm;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
  endfunction

  // Issues one instruction from T0 and reports the cycle count to Done plus the T2 ALU inputs.
  task automatic exec(input logic [15:0] ir, input logic [15:0] imm, output int lat,
                      output logic [3:0] op2, output logic [15:0] a2, output logic [15:0] b2);
    op2 = 4'h0; a2 = 16'h0; b2 = 16'h0;
    @(negedge clk); bus.Run = 1'b1; bus.DIN = ir;
    @(negedge clk); bus.Run = 1'b0; bus.DIN = imm; lat = 2;
    while (bus.Done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin op2 = bus.alu_op; a2 = bus.alu_a; b2 = bus.alu_b; end
    end
    $display("txn ir=%04h imm=%04h latency=%0d", ir, imm, lat);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    bus.Run = 1'b0; bus.DIN = 16'h0; bus.dbg_sel = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.Done); end
    checks++; if (bus.alu_op !== 4'h0) begin errors++; $display("FAIL reset_alu_op got %h expected 0", bus.alu_op); end
    checks++; if (bus.alu_a !== 16'h0) begin errors++; $display("FAIL reset_alu_a got %h expected 0", bus.alu_a); end
    checks++; if (bus.alu_b !== 16'h0) begin errors++; $display("FAIL reset_alu_b got %h expected 0", bus.alu_b); end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_sel = i[2:0]; #1; v = bus.dbg_data;
      checks++; if (v !== m_reg[i]) begin errors++; $display("FAIL reset_reg R%0d got %h expected %h", i, v, m_reg[i]); end
    end
  endtask

  task automatic test_mv_mvi();
    int lat; logic [3:0] op2; logic [15:0] a2, b2, v;
    exec(16'h7200, 16'h00FF, lat, op2, a2, b2); model_exec(16'h7200, 16'h00FF);
    checks++; if (lat != 2) begin errors++; $display("FAIL mvi_latency got %0d expected 2", lat); end
    exec(16'h6440, 16'h0000, lat, op2, a2, b2); model_exec(16'h6440, 16'h0000);
    checks++; if (lat != 2) begin errors++; $display("FAIL mv_latency got %0d expected 2", lat); end
    @(negedge clk);
    bus.dbg_sel = 3'd1; #1; v = bus.dbg_data;
    checks++; if (v !== 16'h00FF) begin errors++; $display("FAIL mvi_r1 got %h expected 00ff", v); end
    bus.dbg_sel = 3'd2; #1; v = bus.dbg_data;
    checks++; if (v !== 16'h00FF) begin errors++; $display("FAIL mv_r2 got %h expected 00ff", v); end
    exec(16'h66C0, 16'h0000, lat, op2, a2, b2); model_exec(16'h66C0, 16'h0000);
    @(negedge clk);
    bus.dbg_sel = 3'd3; #1; v = bus.dbg_data;
    checks++; if (v !== m_reg[3]) begin errors++; $display("FAIL mv_self_r3 got %h expected %h", v, m_reg[3]); end
  endtask

  task automatic test_alu_directed();
    int lat; logic [3:0] op2; logic [15:0] a2, b2, v;
    exec(16'h7200, 16'hFFFF, lat, op2, a2, b2); model_exec(16'h7200, 16'hFFFF);
    exec(16'h7400, 16'h0002, lat, op2, a2, b2); model_exec(16'h7400, 16'h0002);
    exec(16'h0280, 16'h0000, lat, op2, a2, b2); model_exec(16'h0280, 16'h0000);
    checks++; if (lat != 4) begin errors++; $display("FAIL add_latency got %0d expected 4", lat); end
    checks++; if (op2 !== 4'h0) begin errors++; $display("FAIL add_alu_op got %h expected 0", op2); end
    @(negedge clk); bus.dbg_sel = 3'd1; #1; v = bus.dbg_data;
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL add_wrap_r1 got %h expected 0001", v); end
    exec(16'h7600, 16'h0005, lat, op2, a2, b2); model_exec(16'h7600, 16'h0005);
    exec(16'h7800, 16'h0009, lat, op2, a2, b2); model_exec(16'h7800, 16'h0009);
    exec(16'h2700, 16'h0000, lat, op2, a2, b2); model_exec(16'h2700, 16'h0000);
    checks++; if (op2 !== 4'h2) begin errors++; $display("FAIL slt_alu_op got %h expected 2", op2); end
    exec(16'h1900, 16'h0000, lat, op2, a2, b2); model_exec(16'h1900, 16'h0000);
    @(negedge clk); bus.dbg_sel = 3'd3; #1; v = bus.dbg_data;
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL slt_r3 got %h expected 0001", v); end
    bus.dbg_sel = 3'd4; #1; v = bus.dbg_data;
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL sub_self_r4 got %h expected 0000", v); end
    exec(16'h7A00, 16'h0001, lat, op2, a2, b2); model_exec(16'h7A00, 16'h0001);
    exec(16'h7C00, 16'h0004, lat, op2, a2, b2); model_exec(16'h7C00, 16'h0004);
    exec(16'h3B80, 16'h0000, lat, op2, a2, b2); model_exec(16'h3B80, 16'h0000);
    @(negedge clk); bus.dbg_sel = 3'd5; #1; v = bus.dbg_data;
    checks++; if (v !== 16'h0010) begin errors++; $display("FAIL sll_r5 got %h expected 0010", v); end
    exec(16'h7C00, 16'h0014, lat, op2, a2, b2); model_exec(16'h7C00, 16'h0014);
    exec(16'h4B80, 16'h0000, lat, op2, a2, b2); model_exec(16'h4B80, 16'h0000);
    checks++; if (b2 !== 16'h0014) begin errors++; $display("FAIL slr_alu_b got %h expected 0014", b2); end
    @(negedge clk); bus.dbg_sel = 3'd5; #1; v = bus.dbg_data;
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL slr_big_r5 got %h expected 0000", v); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [3:0] op2; logic [15:0] a2, b2, v;
    exec(16'h7200, 16'h1111, lat, op2, a2, b2); model_exec(16'h7200, 16'h1111);
    @(negedge clk); bus.Run = 1'b1; bus.DIN = 16'h0280;
    @(negedge clk); bus.Run = 1'b0;
    @(negedge clk);
    checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_t2 got %b expected 1", bus.Busy); end
    rst = 1'b1; #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b expected 0", bus.Done); end
    checks++; if (bus.alu_a !== 16'h0) begin errors++; $display("FAIL midrst_alu_a got %h expected 0", bus.alu_a); end
    @(negedge clk); rst = 1'b0; model_reset();
    for (int i = 0; i < 8; i++) begin
      bus.dbg_sel = i[2:0]; #1; v = bus.dbg_data;
      checks++; if (v !== m_reg[i]) begin errors++; $display("FAIL midrst_reg R%0d got %h expected %h", i, v, m_reg[i]); end
    end
    exec(16'h7E00, 16'h1234, lat, op2, a2, b2); model_exec(16'h7E00, 16'h1234);
    checks++; if (lat != 2) begin errors++; $display("FAIL midrst_next_latency got %0d expected 2", lat); end
    @(negedge clk); bus.dbg_sel = 3'd7; #1; v = bus.dbg_data;
    checks++; if (v !== 16'h1234) begin errors++; $display("FAIL midrst_next_r7 got %h expected 1234", v); end
  endtask

  task automatic test_busy_ignore();
    int lat; logic [3:0] op2; logic [15:0] a2, b2, v;
    exec(16'h7200, 16'h0003, lat, op2, a2, b2); model_exec(16'h7200, 16'h0003);
    exec(16'h7400, 16'h0004, lat, op2, a2, b2); model_exec(16'h7400, 16'h0004);
    @(negedge clk); bus.Run = 1'b1; bus.DIN = 16'h0280;
    @(negedge clk); bus.Run = 1'b1; bus.DIN = 16'h7E00;
    @(negedge clk); bus.Run = 1'b1;
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL busy_t2_done got %b expected 0", bus.Done); end
    @(negedge clk); bus.Run = 1'b0;
    checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL busy_t3_done got %b expected 1", bus.Done); end
    @(negedge clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL busy_back_idle got %b expected 0", bus.Busy); end
    $display("txn ir=0280 with Run pulsed while busy");
    model_exec(16'h0280, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_sel = i[2:0]; #1; v = bus.dbg_data;
      checks++; if (v !== m_reg[i]) begin errors++; $display("FAIL busy_reg R%0d got %h expected %h", i, v, m_reg[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    @(negedge clk); bus.Run = 1'b1; bus.DIN = 16'hF000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (bus.Done !== ((k % 2) == 0)) begin errors++; $display("FAIL b2b_done k=%0d got %b expected %b", k, bus.Done, (k % 2) == 0); end
      checks++; if (bus.Busy !== ((k % 2) == 0)) begin errors++; $display("FAIL b2b_busy k=%0d got %b expected %b", k, bus.Busy, (k % 2) == 0); end
      if (k == 5) bus.Run = 1'b0;
      $display("txn ir=f000 illegal refetch cycle=%0d", k);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_sel = i[2:0]; #1; v = bus.dbg_data;
      checks++; if (v !== m_reg[i]) begin errors++; $display("FAIL illegal_reg R%0d got %h expected %h", i, v, m_reg[i]); end
    end
  endtask

  task automatic test_random();
    int lat, x, y, exp_lat;
    logic [3:0] op2; logic [15:0] a2, b2, v, ir, imm, old_x, old_y;
    for (int n = 0; n < 40; n++) begin
      ir = 16'($urandom); imm = 16'($urandom);
      x = int'(ir[11:9]); y = int'(ir[8:6]);
      old_x = m_reg[x]; old_y = m_reg[y];
      exp_lat = (ir[15:12] <= 4'd5) ? 4 : 2;
      exec(ir, imm, lat, op2, a2, b2);
      model_exec(ir, imm);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd_latency ir=%h got %0d expected %0d", ir, lat, exp_lat); end
      if (exp_lat == 4) begin
        checks++; if (op2 !== ir[15:12]) begin errors++; $display("FAIL rnd_alu_op ir=%h got %h expected %h", ir, op2, ir[15:12]); end
        checks++; if (a2 !== old_x) begin errors++; $display("FAIL rnd_alu_a ir=%h got %h expected %h", ir, a2, old_x); end
        checks++; if (b2 !== old_y) begin errors++; $display("FAIL rnd_alu_b ir=%h got %h expected %h", ir, b2, old_y); end
      end
      @(negedge clk); bus.dbg_sel = ir[11:9]; #1; v = bus.dbg_data;
      checks++; if (v !== m_reg[x]) begin errors++; $display("FAIL rnd_rx ir=%h R%0d got %h expected %h", ir, x, v, m_reg[x]); end
    end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_sel = i[2:0]; #1; v = bus.dbg_data;
      checks++; if (v !== m_reg[i]) begin errors++; $display("FAIL rnd_final R%0d got %h expected %h", i, v, m_reg[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_mv_mvi();
    test_alu_directed();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
